// File: rtl/hazard_branch_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/branch controller: forwarding selects,
// branch funct3 codes and sequencing states.
package hazard_branch_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // Flush timer only needs to hold FLUSH_CYCLES-1, at most 3.
  localparam int TMR_W = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_branch_ctrl_forward_unit.sv
// ALU operand forwarding for both EX-stage sources; EX/MEM result beats MEM/WB,
// and x0 is never forwarded.
module hazard_branch_ctrl_forward_unit
  import hazard_branch_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input logic [REG_W-1:0] m_rd,
                                         input logic             m_we,
                                         input logic [REG_W-1:0] w_rd,
                                         input logic             w_we);
    logic [1:0] sel;
    sel = FWD_REG;
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      sel = FWD_MEM;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(src_a, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b = fwd_sel(src_b, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

endmodule

// File: rtl/hazard_branch_ctrl.sv
// Pipeline sequencing controller: EX branch redirect, load-use bubble, forwarding,
// external freeze and stall/flush performance counters.
//
//   state    | meaning
//   ST_RUN   | normal issue; redirects, bubbles and freezes resolved per cycle
//   ST_FLUSH | IF/ID held flushed while fetch drains after a redirect
module hazard_branch_ctrl
  import hazard_branch_ctrl_pkg::*;
#(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_stall,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_alu_zero,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [1:0]         fwd_a_raw, fwd_b_raw;
  logic               taken, load_use;

  hazard_branch_ctrl_forward_unit #(.REG_W(REG_W)) u_fwd (
    .src_a         (ex_rs1),
    .src_b         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  assign taken = ex_branch && (((ex_funct3 == F3_BEQ) && ex_alu_zero) ||
                               ((ex_funct3 == F3_BNE) && !ex_alu_zero));
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_write    = 1'b1;
    pc_sel      = 1'b0;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;

    if (reset) begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ext_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else if (taken) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
            if (FLUSH_CYCLES > 1) begin
              timer_d = TMR_W'(FLUSH_CYCLES - 1);
              state_d = ST_FLUSH;
            end
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          // Shadow instructions: branches and load-use in this window are discarded.
          if_id_flush = 1'b1;
          if (ext_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end else begin
            timer_d = timer_q - TMR_W'(1);
            if (timer_q == TMR_W'(1)) begin
              state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
